// File: rtl/seg_display_mux.sv
// Four-digit multiplexed 7-segment driver with per-slot anti-ghost blanking and frame-latched inputs.
// Optional leading-zero suppression when SEG_DISPLAY_MUX_ZERO_BLANK_EN is defined.
module seg_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);
    // state | meaning
    // DIG0  | scanning digit 0 (rightmost)
    // DIG1  | scanning digit 1
    // DIG2  | scanning digit 2
    // DIG3  | scanning digit 3; its last slot cycle latches the next frame
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } state_t;

    localparam int            CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    state_t        state;
    logic [CW-1:0] slot_cnt;
    logic [15:0]   shadow_digits;
    logic [3:0]    shadow_dp;

    logic [3:0] cur_code;
    logic       cur_dp;
    logic [3:0] cur_an;
    logic       cur_blank;
    logic [6:0] cur_seg;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        case (code)
            4'd0:    bcd_to_seg = 7'b1000000;
            4'd1:    bcd_to_seg = 7'b1111001;
            4'd2:    bcd_to_seg = 7'b0100100;
            4'd3:    bcd_to_seg = 7'b0110000;
            4'd4:    bcd_to_seg = 7'b0011001;
            4'd5:    bcd_to_seg = 7'b0010010;
            4'd6:    bcd_to_seg = 7'b0000010;
            4'd7:    bcd_to_seg = 7'b1111000;
            4'd8:    bcd_to_seg = 7'b0000000;
            4'd9:    bcd_to_seg = 7'b0010000;
            default: bcd_to_seg = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        cur_code  = shadow_digits[3:0];
        cur_dp    = shadow_dp[0];
        cur_an    = 4'b1110;
        cur_blank = 1'b0;
        case (state)
            DIG0: begin
                cur_code = shadow_digits[3:0];
                cur_dp   = shadow_dp[0];
                cur_an   = 4'b1110;
            end
            DIG1: begin
                cur_code = shadow_digits[7:4];
                cur_dp   = shadow_dp[1];
                cur_an   = 4'b1101;
            end
            DIG2: begin
                cur_code = shadow_digits[11:8];
                cur_dp   = shadow_dp[2];
                cur_an   = 4'b1011;
            end
            DIG3: begin
                cur_code = shadow_digits[15:12];
                cur_dp   = shadow_dp[3];
                cur_an   = 4'b0111;
            end
            default: ;
        endcase
`ifdef SEG_DISPLAY_MUX_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit to its left are zero.
        case (state)
            DIG1:    cur_blank = (shadow_digits[15:4] == 12'd0);
            DIG2:    cur_blank = (shadow_digits[15:8] == 8'd0);
            DIG3:    cur_blank = (shadow_digits[15:12] == 4'd0);
            default: cur_blank = 1'b0;
        endcase
`endif
        cur_seg = cur_blank ? 7'b1111111 : bcd_to_seg(cur_code);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= DIG0;
            slot_cnt      <= '0;
            shadow_digits <= 16'd0;
            shadow_dp     <= 4'd0;
            an            <= 4'b1111;
            seg           <= 7'b1111111;
            dp            <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (slot_cnt == CNT_LAST) begin
                slot_cnt <= '0;
                case (state)
                    DIG0: state <= DIG1;
                    DIG1: state <= DIG2;
                    DIG2: state <= DIG3;
                    DIG3: begin
                        state         <= DIG0;
                        shadow_digits <= digits;
                        shadow_dp     <= dp_mask;
                        frame_done    <= 1'b1;
                    end
                    default: state <= DIG0;
                endcase
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end

            if (slot_cnt < CNT_BLANK) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= cur_an;
                seg <= cur_seg;
                dp  <= ~cur_dp;
            end
        end
    end
endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: directed scenarios then random traffic,
// every cycle compared against a position-based reference model.
module tb_seg_display_mux;
    localparam int R = 8;
    localparam int B = 2;
    localparam int FRAME = 4 * R;
`ifdef SEG_DISPLAY_MUX_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // reference state: edges since reset release and the latched frame contents
    int k = 0;
    int m_dig = 0;
    int m_dp = 0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;

    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    seg_display_mux #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (k=%0d)", tag, got, exp, k);
        end
    endtask

    // One clock: predict outputs from the scan position, then compare after the edge.
    task automatic step();
        int pos, c, slot, code, upper;
        @(posedge clk);
        if (reset) begin
            k = 0;
            m_dig = 0;
            m_dp = 0;
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            k++;
            pos  = k - 1;
            c    = pos % R;
            slot = (pos / R) % 4;
            e_fd = ((k % FRAME) == 0);
            if (c < B) begin
                e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
            end else begin
                upper = m_dig >> (4 * slot);
                code  = upper & 15;
                e_an  = 4'b1111 & ~(4'b0001 << slot);
                e_seg = (ZB && slot != 0 && upper == 0) ? 7'b1111111 : seg_tab[code];
                e_dp  = ~((m_dp >> slot) & 1);
            end
            if (e_fd) begin
                m_dig = int'(digits);
                m_dp  = int'(dp_mask);
            end
        end
        #1;
        chk("an", {3'b000, an}, {3'b000, e_an});
        chk("seg", seg, e_seg);
        chk("dp", {6'd0, dp}, {6'd0, e_dp});
        chk("frame_done", {6'd0, frame_done}, {6'd0, e_fd});
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        reset = 1'b1;
        digits = 16'h0000;
        dp_mask = 4'b0000;
        repeat (3) step();

        // normal display of 1234 with the rightmost point lit
        reset = 1'b0;
        digits = 16'h1234;
        dp_mask = 4'b0001;
        run_to(36);
        chk("dig0_an", {3'b000, an}, 7'b0001110);
        chk("dig0_seg", seg, 7'b0011001);
        chk("dig0_dp", {6'd0, dp}, 7'd0);

        // input change mid-DIG1 must not tear the frame in progress
        run_to(42);
        digits = 16'h9999;
        run_to(60);
        chk("dig3_an", {3'b000, an}, 7'b0000111);
        chk("dig3_seg", seg, 7'b1111001);
        chk("dig3_dp", {6'd0, dp}, 7'd1);

        // dash and leading-zero handling
        run_to(70);
        digits = 16'h00A7;
        dp_mask = 4'b0000;
        run_to(100);
        chk("a7_dig0_seg", seg, 7'b1111000);
        run_to(108);
        chk("a7_dig1_seg", seg, 7'b0111111);
        run_to(124);
        chk("a7_dig3_seg", seg, ZB ? 7'b1111111 : 7'b1000000);

        // one-cycle reset in the middle of DIG2
        run_to(FRAME * 4 + 18);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_to(40);

        // random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 19) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) digits[15:8] = 8'h00;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        run_to(FRAME * 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal range is 4 or more.
REQ-002 SHALL have parameter BLANK_CYC, default 16: anti-ghosting cycles at the start of each slot; legal range is 1 to REFRESH_DIV-2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port digits, input, 16 bits: four BCD digits; [3:0] is digit0 (least significant, rightmost), [15:12] is digit3.
REQ-006 SHALL have port dp_mask, input, 4 bits: decimal-point request, bit i for digit i, 1 means point on.
REQ-007 SHALL have port an, output, 4 bits: active-low anode enables; bit i drives digit i.
REQ-008 SHALL have port seg, output, 7 bits: active-low segments ordered {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse marking the end of a scan frame.

Function
REQ-011 SHALL keep a slot counter that runs 0 to REFRESH_DIV-1 and wraps to 0.
REQ-012 SHALL use a scan FSM with states DIG0, DIG1, DIG2, DIG3, advancing DIG0->DIG1->DIG2->DIG3->DIG0 on each slot-counter wrap.
REQ-013 SHALL capture digits and dp_mask into shadow registers on the cycle DIG3 wraps to DIG0, and SHALL pulse frame_done high for exactly that cycle; the frame period is 4*REFRESH_DIV cycles.
REQ-014 SHALL drive the display only from the shadow registers; input changes mid-frame SHALL NOT alter any output until the next capture.
REQ-015 SHALL register an, seg and dp, so they reflect the FSM state and slot counter with one cycle of latency.
REQ-016 SHALL hold an=4'b1111 (all anodes off) while the slot counter is below BLANK_CYC.
REQ-017 SHALL otherwise drive exactly one an bit low, namely the bit of the current state.
REQ-018 SHALL decode BCD 0-9 to seg as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL display codes 10-15 as a dash, seg=0111111.
REQ-020 SHALL drive dp low only when the shadow dp_mask bit of the active digit is 1.
REQ-021 SHALL drive seg=1111111 and dp=1 during the blanking window.
REQ-022 SHALL, when a capture and a digits change occur in the same cycle, capture the value present at that clock edge.

Reset
REQ-023 SHALL, on reset, take the following values at the next rising clk edge: an=1111, seg=1111111, dp=1, frame_done=0, slot counter=0, FSM=DIG0, shadow digits=0, shadow dp_mask=0.
REQ-024 SHALL, when reset is asserted mid-frame, abandon the frame with no frame_done pulse and restart the scan at DIG0 slot count 0 after reset deasserts.
REQ-025 SHALL leave outputs at their reset values while reset is held, regardless of other inputs.

Configuration
REQ-026 SHALL recognise the macro SEG_DISPLAY_MUX_ZERO_BLANK_EN.
REQ-027 SHALL, when that macro is defined, blank leading zeros: digit3 is blanked if its shadow value is 0; digit2 if it and digit3 are 0; digit1 if it, digit2 and digit3 are 0. Digit0 is never blanked.
REQ-028 SHALL, for a blanked digit, drive seg=1111111 while still asserting its anode and still honouring dp_mask.
REQ-029 SHALL, when that macro is not defined, display all four digits unconditionally.

Verification
REQ-030 SHALL cover reset (REFRESH_DIV=8, BLANK_CYC=2): hold reset 3 cycles -> an=1111, seg=1111111, dp=1, frame_done=0 throughout.
REQ-031 SHALL cover display: digits=16'h1234, dp_mask=0001 -> after the first frame_done, the DIG0 active window shows an=1110, seg=0011001, dp=0, and the DIG3 window shows an=0111, seg=1111001, dp=1.
REQ-032 SHALL cover timing: free-running -> frame_done every 32 cycles, high for 1 cycle; the first 2 cycles of every slot show an=1111.
REQ-033 SHALL cover tearing: digits change from 16'h1234 to 16'h9999 mid-DIG1 -> DIG1 to DIG3 still show 3, 2, 1; 9 appears only after the next frame_done.
REQ-034 SHALL cover dash and blanking: digits=16'h00A7 -> DIG1 seg=0111111 and DIG0 seg=1111000. DIG3/DIG2 seg=1111111 with the macro, 1000000 without.
REQ-035 SHALL cover mid-frame reset: reset asserted 1 cycle during DIG2 -> reset values next edge; after release, DIG0 is entered first and there is no frame_done until 32 cycles later.
